// File: rtl/fifo_feeder.sv
// fifo_feeder: pops FEED_LEN words from an upstream FIFO per start pulse, registers them
// toward a systolic row, then pads with FLUSH_LEN zero words and pulses done_o.
// Optional macro FEEDER_STALL_CNT_EN adds stall_cnt_o, a saturating per-burst stall counter.
module fifo_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int FEED_LEN   = 8,
    parameter int FLUSH_LEN  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rden_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt_o
`endif
);
    localparam int CW = $clog2(FEED_LEN + FLUSH_LEN + 1);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_done;
    logic [CW-1:0]         w_cnt_nxt;

    assign w_cnt_nxt   = r_cnt + 1'b1;
    assign fifo_rden_o = rst_n && (r_state == FEED) && !fifo_empty_i;
    assign busy_o      = rst_n && (r_state != IDLE);
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign done_o      = r_done;

    // Burst FSM: data/valid/done default to zero each cycle and are set only where meaningful.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: if (start_i) r_state <= FEED;
                FEED: if (!fifo_empty_i) begin
                    r_data  <= fifo_rdata_i;
                    r_valid <= 1'b1;
                    if (w_cnt_nxt == CW'(FEED_LEN)) begin
                        r_cnt   <= '0;
                        r_state <= (FLUSH_LEN == 0) ? DONE : FLUSH;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                FLUSH: begin
                    r_valid <= 1'b1;
                    if (w_cnt_nxt == CW'(FLUSH_LEN)) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Stall counter: cleared when a burst is accepted, saturates, holds outside FEED.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (r_state == IDLE && start_i)
            r_stall_cnt <= '0;
        else if (r_state == FEED && fifo_empty_i && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fifo_feeder.sv
// tb_fifo_feeder: directed bench for fifo_feeder with three parameterisations
// (default 8/7 behind a FIFO model, FEED_LEN=2 with scheduled stalls, FEED_LEN=1/FLUSH_LEN=0 vector table).
// Honours FEEDER_STALL_CNT_EN when the macro is defined.
module tb_fifo_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start_a = 1'b0, empty_a = 1'b1, rden_a, valid_a, busy_a, done_a;
    logic [31:0] rdata_a = '0, data_a;
    logic        start_b = 1'b0, empty_b = 1'b1, rden_b, valid_b, busy_b, done_b;
    logic [7:0]  rdata_b = '0, data_b;
    logic        start_c = 1'b0, empty_c = 1'b1, rden_c, valid_c, busy_c, done_c;
    logic [7:0]  rdata_c = '0, data_c;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_a, stall_b, stall_c;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_bad = 0;
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    fifo_feeder u_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .fifo_empty_i(empty_a),
        .fifo_rdata_i(rdata_a), .fifo_rden_o(rden_a), .data_o(data_a),
        .valid_o(valid_a), .busy_o(busy_a), .done_o(done_a)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cnt_o(stall_a)
`endif
    );

    fifo_feeder #(.DATA_WIDTH(8), .FEED_LEN(2), .FLUSH_LEN(7)) u_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .fifo_empty_i(empty_b),
        .fifo_rdata_i(rdata_b), .fifo_rden_o(rden_b), .data_o(data_b),
        .valid_o(valid_b), .busy_o(busy_b), .done_o(done_b)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cnt_o(stall_b)
`endif
    );

    fifo_feeder #(.DATA_WIDTH(8), .FEED_LEN(1), .FLUSH_LEN(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start_i(start_c), .fifo_empty_i(empty_c),
        .fifo_rdata_i(rdata_c), .fifo_rden_o(rden_c), .data_o(data_c),
        .valid_o(valid_c), .busy_o(busy_c), .done_o(done_c)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cnt_o(stall_c)
`endif
    );

    // Upstream FIFO model for u_a: the pop happens on the edge where rden is seen.
    always @(posedge clk) begin
        if (rden_a) begin
            if (empty_a) n_bad++;
            else begin
                rd_ptr++;
                n_pop++;
            end
        end
    end

    typedef struct packed {
        logic       rst;
        logic       st;
        logic       emp;
        logic [7:0] rd;
        logic       rden;
        logic       val;
        logic [7:0] dat;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tv [0:10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic cyc();
        @(negedge clk);
        empty_a = (wr_ptr == rd_ptr);
        rdata_a = mem[rd_ptr];
    endtask

    task automatic run_burst(input int base);
        int p0 = n_pop;
        cyc();
        start_a = 1'b1;
        #1;
        chk("burst_idle_busy", busy_a, 0);
        for (int j = 1; j <= 18; j++) begin
            cyc();
            start_a = (j == 4 || j == 12);
            #1;
            chk("burst_valid", valid_a, j >= 2 && j <= 16);
            chk("burst_data", data_a, (j >= 2 && j <= 9) ? base + j - 2 : 0);
            chk("burst_done", done_a, j == 17);
            chk("burst_busy", busy_a, j <= 16);
        end
        start_a = 1'b0;
        chk("burst_pops", n_pop - p0, 8);
    endtask

    initial begin
        int nd;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        tv[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[10] = '{1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        cyc();
        cyc();
        #1;
        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_rden", rden_a, 0);
`ifdef FEEDER_STALL_CNT_EN
        chk("rst_stall", stall_b, 0);
`endif
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) push(i);
        run_burst(1);

        for (int i = 0; i < 8; i++) push(101 + i);
        cyc();
        start_a = 1'b1;
        #1;
        for (int j = 1; j <= 3; j++) begin
            cyc();
            start_a = 1'b0;
            #1;
            chk("pre_rst_rden", rden_a, 1);
        end
        cyc();
        rst_n = 1'b0;
        #1;
        chk("in_rst_rden", rden_a, 0);
        chk("in_rst_busy", busy_a, 0);
        chk("in_rst_data", data_a, 103);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_rst_valid", valid_a, 0);
        chk("post_rst_data", data_a, 0);
        chk("post_rst_busy", busy_a, 0);
        chk("post_rst_rden", rden_a, 0);
        nd = 0;
        for (int j = 0; j < 20; j++) begin
            cyc();
            #1;
            nd += int'(done_a) + int'(busy_a);
        end
        chk("post_rst_no_done", nd, 0);
        chk("post_rst_left", wr_ptr - rd_ptr, 5);
        for (int i = 0; i < 3; i++) push(109 + i);
        run_burst(104);

        for (int i = 0; i < 12; i++) push(201 + i);
        run_burst(201);
        cyc();
        start_a = 1'b1;
        #1;
        for (int j = 1; j <= 21; j++) begin
            cyc();
            start_a = 1'b0;
            if (j == 7) for (int i = 0; i < 4; i++) push(213 + i);
            #1;
            chk("b2b_rden", rden_a, j <= 4 || (j >= 8 && j <= 11));
            chk("b2b_valid", valid_a, (j >= 2 && j <= 5) || (j >= 9 && j <= 19));
            chk("b2b_data", data_a, (j >= 2 && j <= 5) ? 207 + j : (j >= 9 && j <= 12) ? 204 + j : 0);
            chk("b2b_done", done_a, j == 20);
            chk("b2b_busy", busy_a, j <= 19);
        end
        chk("pop_while_empty", n_bad, 0);

        cyc();
        start_b = 1'b1;
        #1;
        for (int k = 0; k <= 16; k++) begin
            cyc();
            start_b = 1'b0;
            empty_b = !(k == 2 || k == 5 || k >= 7);
            rdata_b = (k == 2) ? 8'h0A : (k == 5) ? 8'h0B : 8'hEE;
            #1;
            chk("stall_rden", rden_b, k == 2 || k == 5);
            chk("stall_valid", valid_b, k == 3 || k == 6 || (k >= 7 && k <= 13));
            chk("stall_data", data_b, (k == 3) ? 8'h0A : (k == 6) ? 8'h0B : 8'h00);
            chk("stall_done", done_b, k == 14);
            chk("stall_busy", busy_b, k <= 13);
        end
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cnt", stall_b, 4);
`endif
        empty_b = 1'b1;

        for (int i = 0; i <= 10; i++) begin
            cyc();
            rst_n   = tv[i].rst;
            start_c = tv[i].st;
            empty_c = tv[i].emp;
            rdata_c = tv[i].rd;
            #1;
            chk("vec_rden", rden_c, tv[i].rden);
            chk("vec_valid", valid_c, tv[i].val);
            chk("vec_data", data_c, tv[i].dat);
            chk("vec_busy", busy_c, tv[i].busy);
            chk("vec_done", done_c, tv[i].done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
